// File: rtl/cmp8_scan_ctrl.sv
// cmp8_scan_ctrl: scans an 8-entry pattern table through an external 8-bit
// equality comparator and reports which entries match a latched search key.
// Optional feature: define CMP8_SCAN_ALL_EN to sample all 8 entries every scan;
// left undefined, the scan stops at the first matching entry.
//
// Write port: wr_en / wr_clr are single-cycle strobes. They are honored at the
// next rising edge only when busy=0. When busy=1 they are dropped, and wr_err
// pulses for one cycle after the drop.
module cmp8_scan_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       wr_clr,
    input  logic       start,
    input  logic [7:0] key,
    output logic       cmp_g,
    output logic [7:0] cmp_p,
    output logic [7:0] cmp_q,
    input  logic       cmp_eq_n,
    output logic       busy,
    output logic       done,
    output logic       hit,
    output logic [2:0] hit_idx,
    output logic [7:0] hit_mask,
    output logic       wr_err,
    output logic [1:0] dbg_state
);

`ifdef CMP8_SCAN_ALL_EN
    localparam bit FIRST_HIT = 1'b0;
`else
    localparam bit FIRST_HIT = 1'b1;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [1:0]  settle_q, settle_d;
    logic [7:0]  cmp_p_q, cmp_p_d;
    logic [7:0]  cmp_q_q, cmp_q_d;
    logic        hit_q, hit_d;
    logic [2:0]  hit_idx_q, hit_idx_d;
    logic [7:0]  hit_mask_q, hit_mask_d;
    logic        wr_err_q, wr_err_d;
    logic [7:0]  valid_q, valid_d;
    logic [7:0]  data_q [8];
    logic [7:0]  data_d [8];

    logic        busy_w;
    logic        match_w;

    assign busy_w  = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
    assign match_w = !cmp_eq_n && valid_q[idx_q];

    // Next-state logic for the scan FSM, table writes and result registers.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        settle_d   = settle_q;
        cmp_p_d    = cmp_p_q;
        cmp_q_d    = cmp_q_q;
        hit_d      = hit_q;
        hit_idx_d  = hit_idx_q;
        hit_mask_d = hit_mask_q;
        valid_d    = valid_q;
        data_d     = data_q;
        wr_err_d   = busy_w && (wr_en || wr_clr);

        // The table is frozen during a scan so cmp_q cannot change mid-phase.
        if (!busy_w) begin
            if (wr_clr) begin
                valid_d[wr_addr] = 1'b0;
            end else if (wr_en) begin
                data_d[wr_addr]  = wr_data;
                valid_d[wr_addr] = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cmp_p_d    = key;
                    cmp_q_d    = data_q[0];
                    idx_d      = 3'd0;
                    settle_d   = 2'd0;
                    hit_d      = 1'b0;
                    hit_idx_d  = 3'd0;
                    hit_mask_d = 8'd0;
                    state_d    = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (settle_q == 2'(SETTLE - 1)) begin
                    settle_d = 2'd0;
                    state_d  = S_SAMPLE;
                end else begin
                    settle_d = settle_q + 2'd1;
                end
            end
            S_SAMPLE: begin
                if (match_w) begin
                    hit_mask_d[idx_q] = 1'b1;
                    hit_d             = 1'b1;
                    if (!hit_q) begin
                        hit_idx_d = idx_q;
                    end
                end
                if ((idx_q == 3'd7) || (match_w && FIRST_HIT)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d    = idx_q + 3'd1;
                    cmp_q_d  = data_q[idx_q + 3'd1];
                    settle_d = 2'd0;
                    state_d  = S_DRIVE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and result registers; reset returns everything to IDLE at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= 3'd0;
            settle_q   <= 2'd0;
            cmp_p_q    <= 8'd0;
            cmp_q_q    <= 8'd0;
            hit_q      <= 1'b0;
            hit_idx_q  <= 3'd0;
            hit_mask_q <= 8'd0;
            wr_err_q   <= 1'b0;
            valid_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            settle_q   <= settle_d;
            cmp_p_q    <= cmp_p_d;
            cmp_q_q    <= cmp_q_d;
            hit_q      <= hit_d;
            hit_idx_q  <= hit_idx_d;
            hit_mask_q <= hit_mask_d;
            wr_err_q   <= wr_err_d;
            valid_q    <= valid_d;
        end
    end

    // Pattern data needs no reset: the valid bits alone gate matching.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign cmp_g     = !busy_w;
    assign busy      = busy_w;
    assign done      = (state_q == S_DONE);
    assign cmp_p     = cmp_p_q;
    assign cmp_q     = cmp_q_q;
    assign hit       = hit_q;
    assign hit_idx   = hit_idx_q;
    assign hit_mask  = hit_mask_q;
    assign wr_err    = wr_err_q;
    assign dbg_state = state_q;

endmodule
